// File: rtl/replacement_policy.sv
// rtl/replacement_policy.sv - cache victim-way selection: round-robin, tree-PLRU or LFSR-random
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   access_en       touch of (access_index, access_way); updates that set's recency state
//   lookup_en       victim request qualifier; only feeds the stall counter
//   lookup_index    set whose victim is reported on victim_way
//   valid_mask      line-valid bits of the lookup set
//   lock_mask       ways never chosen as victims (applies to every set)
//   victim_way      chosen victim, combinational from current state and lookup inputs
//   victim_valid    1 when at least one way is unlocked
//   stall_cnt       saturating count of lookup cycles that found no usable way
module replacement_policy #(
  parameter int          NUM_SETS   = 64,
  parameter int          NUM_WAYS   = 4,
  parameter int          POLICY     = 1,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1,
  localparam int         INDEX_BITS = $clog2(NUM_SETS),
  localparam int         WAY_BITS   = $clog2(NUM_WAYS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  access_en,
  input  logic [INDEX_BITS-1:0] access_index,
  input  logic [WAY_BITS-1:0]   access_way,
  input  logic                  lookup_en,
  input  logic [INDEX_BITS-1:0] lookup_index,
  input  logic [NUM_WAYS-1:0]   valid_mask,
  input  logic [NUM_WAYS-1:0]   lock_mask,
  output logic [WAY_BITS-1:0]   victim_way,
  output logic                  victim_valid,
  output logic [15:0]           stall_cnt
);

  // Policy candidate for lookup_index, before valid/lock filtering.
  logic [WAY_BITS-1:0] cand;

  generate
    if (POLICY == 0) begin : g_rr
      // One pointer per set: the way after the most recently touched one.
      logic [WAY_BITS-1:0] ptr [NUM_SETS];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int s = 0; s < NUM_SETS; s++) begin
            ptr[s] <= '0;
          end
        end else if (access_en) begin
          // Power-of-two way count: natural wrap gives mod NUM_WAYS.
          ptr[access_index] <= access_way + WAY_BITS'(1);
        end
      end

      assign cand = ptr[lookup_index];
    end else if (POLICY == 1) begin : g_plru
      // Heap-ordered tree: node 0 is the root, children of n are 2n+1
      // (lower half) and 2n+2 (upper half). A bit of 1 points upward.
      logic [NUM_WAYS-2:0] tree [NUM_SETS];
      logic [NUM_WAYS-2:0] walk_bits;
      logic [NUM_WAYS-2:0] upd_bits;
      logic [WAY_BITS-1:0] walk_node;
      logic [WAY_BITS-1:0] walk_way;
      logic [WAY_BITS-1:0] upd_node;

      always_comb begin
        walk_bits = tree[lookup_index];
        walk_node = '0;
        walk_way  = '0;
        for (int l = 0; l < WAY_BITS; l++) begin
          walk_way  = (walk_way << 1) | WAY_BITS'(walk_bits[walk_node]);
          walk_node = (walk_node << 1) + WAY_BITS'(1) + WAY_BITS'(walk_bits[walk_node]);
        end
      end

      // Every node on the touched way's path is turned to the other half.
      always_comb begin
        upd_bits = tree[access_index];
        upd_node = '0;
        for (int l = 0; l < WAY_BITS; l++) begin
          upd_bits[upd_node] = ~access_way[WAY_BITS-1-l];
          upd_node = (upd_node << 1) + WAY_BITS'(1) + WAY_BITS'(access_way[WAY_BITS-1-l]);
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int s = 0; s < NUM_SETS; s++) begin
            tree[s] <= '0;
          end
        end else if (access_en) begin
          tree[access_index] <= upd_bits;
        end
      end

      assign cand = walk_way;
    end else begin : g_lfsr
      // Shared Fibonacci LFSR, taps 16,14,13,11; free-running, no per-set state.
      logic [15:0] lfsr;
      logic        unused_inputs;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          lfsr <= LFSR_SEED;
        end else begin
          lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
      end

      assign cand          = lfsr[WAY_BITS-1:0];
      assign unused_inputs = ^{access_en, access_index, access_way, lookup_index};
    end
  endgenerate

  // Victim priority: free unlocked way first, then the candidate, then the
  // next unlocked way above the candidate (the k=0 step covers the candidate).
  logic                found;
  logic [WAY_BITS-1:0] scan_way;

  always_comb begin
    victim_way = '0;
    found      = 1'b0;
    scan_way   = '0;
    for (int i = 0; i < NUM_WAYS; i++) begin
      if (!found && !valid_mask[i] && !lock_mask[i]) begin
        victim_way = WAY_BITS'(i);
        found      = 1'b1;
      end
    end
    for (int k = 0; k < NUM_WAYS; k++) begin
      scan_way = cand + WAY_BITS'(k);
      if (!found && !lock_mask[scan_way]) begin
        victim_way = scan_way;
        found      = 1'b1;
      end
    end
    victim_valid = |(~lock_mask);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (lookup_en && !victim_valid && stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_replacement_policy.sv
// tb/tb_replacement_policy.sv - randomized and directed bench for all three replacement modes
module tb_replacement_policy;
  localparam int NS = 64;
  localparam int NW = 4;
  localparam int WB = 2;
  localparam logic [15:0] SEED = 16'hACE1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          access_en = 1'b0;
  logic [5:0]    access_index = '0;
  logic [WB-1:0] access_way = '0;
  logic          lookup_en = 1'b0;
  logic [5:0]    lookup_index = '0;
  logic [NW-1:0] valid_mask = '1;
  logic [NW-1:0] lock_mask = '0;
  logic [WB-1:0] v0, v1, v2;
  logic          vv0, vv1, vv2;
  logic [15:0]   sc0, sc1, sc2;

  always #5 clk = ~clk;

  replacement_policy #(.NUM_SETS(NS), .NUM_WAYS(NW), .POLICY(0), .LFSR_SEED(SEED)) u_rr (
    .clk(clk), .rst(rst), .access_en(access_en), .access_index(access_index),
    .access_way(access_way), .lookup_en(lookup_en), .lookup_index(lookup_index),
    .valid_mask(valid_mask), .lock_mask(lock_mask), .victim_way(v0),
    .victim_valid(vv0), .stall_cnt(sc0));
  replacement_policy #(.NUM_SETS(NS), .NUM_WAYS(NW), .POLICY(1), .LFSR_SEED(SEED)) u_plru (
    .clk(clk), .rst(rst), .access_en(access_en), .access_index(access_index),
    .access_way(access_way), .lookup_en(lookup_en), .lookup_index(lookup_index),
    .valid_mask(valid_mask), .lock_mask(lock_mask), .victim_way(v1),
    .victim_valid(vv1), .stall_cnt(sc1));
  replacement_policy #(.NUM_SETS(NS), .NUM_WAYS(NW), .POLICY(2), .LFSR_SEED(SEED)) u_lfsr (
    .clk(clk), .rst(rst), .access_en(access_en), .access_index(access_index),
    .access_way(access_way), .lookup_en(lookup_en), .lookup_index(lookup_index),
    .valid_mask(valid_mask), .lock_mask(lock_mask), .victim_way(v2),
    .victim_valid(vv2), .stall_cnt(sc2));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference state. PLRU is kept as one "points upward" flag per
  // (tree level, path prefix), i.e. the half-splitting rule directly.
  int          ptr_m [NS];
  bit          plru_m [NS][WB][NW];
  logic [15:0] lfsr_m;
  int          stall_m;

  function automatic void model_reset();
    for (int s = 0; s < NS; s++) begin
      ptr_m[s] = 0;
      for (int l = 0; l < WB; l++)
        for (int p = 0; p < NW; p++)
          plru_m[s][l][p] = 1'b0;
    end
    lfsr_m  = SEED;
    stall_m = 0;
  endfunction

  function automatic int plru_cand(input int s);
    int w = 0;
    for (int l = 0; l < WB; l++) w = w * 2 + int'(plru_m[s][l][w]);
    return w;
  endfunction

  function automatic void plru_touch(input int s, input int way);
    for (int l = 0; l < WB; l++) begin
      int prefix = way >> (WB - l);
      int half   = (way >> (WB - 1 - l)) & 1;
      plru_m[s][l][prefix] = (half == 0);
    end
  endfunction

  // Returns the victim, or -1 when every way is locked.
  function automatic int pick(input int cand, input logic [NW-1:0] vm, input logic [NW-1:0] lm);
    for (int i = 0; i < NW; i++)
      if (!vm[i] && !lm[i]) return i;
    for (int k = 0; k < NW; k++)
      if (!lm[(cand + k) % NW]) return (cand + k) % NW;
    return -1;
  endfunction

  // Called just after a falling edge; checks mid-cycle, then advances the
  // model across the following rising edge. e0..e2 >= 0 add directed checks.
  task automatic step(input bit a_en, input int a_idx, input int a_way, input bit l_en,
                      input int l_idx, input logic [NW-1:0] vm, input logic [NW-1:0] lm,
                      input int e0, input int e1, input int e2);
    int c [3];
    int p [3];
    int ev;
    access_en    = a_en;
    access_index = 6'(a_idx);
    access_way   = WB'(a_way);
    lookup_en    = l_en;
    lookup_index = 6'(l_idx);
    valid_mask   = vm;
    lock_mask    = lm;
    #1;
    c[0] = ptr_m[l_idx];
    c[1] = plru_cand(l_idx);
    c[2] = int'(lfsr_m) % NW;
    for (int m = 0; m < 3; m++) p[m] = pick(c[m], vm, lm);
    ev = (p[0] >= 0) ? 1 : 0;
    chk("rr_victim",   int'(v0), (p[0] < 0) ? 0 : p[0]);
    chk("plru_victim", int'(v1), (p[1] < 0) ? 0 : p[1]);
    chk("lfsr_victim", int'(v2), (p[2] < 0) ? 0 : p[2]);
    chk("rr_valid",    int'(vv0), ev);
    chk("plru_valid",  int'(vv1), ev);
    chk("lfsr_valid",  int'(vv2), ev);
    chk("rr_stall",    int'(sc0), stall_m);
    chk("plru_stall",  int'(sc1), stall_m);
    chk("lfsr_stall",  int'(sc2), stall_m);
    if (e0 >= 0) chk("rr_directed",   int'(v0), e0);
    if (e1 >= 0) chk("plru_directed", int'(v1), e1);
    if (e2 >= 0) chk("lfsr_directed", int'(v2), e2);
    if (l_en && ev == 0 && stall_m < 65535) stall_m++;
    lfsr_m = {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
    if (a_en) begin
      ptr_m[a_idx] = (a_way + 1) % NW;
      plru_touch(a_idx, a_way);
    end
    @(negedge clk);
  endtask

  // Asynchronous reset asserted mid-cycle with an access pending.
  task automatic do_reset();
    access_en    = 1'b1;
    access_index = 6'd3;
    access_way   = 2'd1;
    lookup_en    = 1'b1;
    lookup_index = 6'd3;
    valid_mask   = '1;
    lock_mask    = '0;
    #2;
    rst = 1'b1;
    #1;
    chk("rst_rr_victim",   int'(v0), 0);
    chk("rst_plru_victim", int'(v1), 0);
    chk("rst_lfsr_victim", int'(v2), int'(SEED) % NW);
    chk("rst_rr_stall",    int'(sc0), 0);
    chk("rst_plru_stall",  int'(sc1), 0);
    chk("rst_lfsr_stall",  int'(sc2), 0);
    model_reset();
    @(negedge clk);
    rst       = 1'b0;
    access_en = 1'b0;
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    do_reset();
    // First candidates after reset release.
    step(0, 0, 0, 1, 0, 4'hF, 4'h0, 0, 0, 1);
    // PLRU walk on set 3.
    step(1, 3, 0, 0, 3, 4'hF, 4'h0, -1, -1, -1);
    step(1, 3, 1, 0, 3, 4'hF, 4'h0, -1, -1, -1);
    step(0, 0, 0, 1, 3, 4'hF, 4'h0, -1, 2, -1);
    step(1, 3, 2, 0, 3, 4'hF, 4'h0, -1, -1, -1);
    step(0, 0, 0, 1, 3, 4'hF, 4'h0, -1, 0, -1);
    // Round-robin wrap on set 5, set 6 untouched.
    step(1, 5, 3, 1, 5, 4'hF, 4'h0, 0, -1, -1);
    step(0, 0, 0, 1, 5, 4'hF, 4'h0, 0, -1, -1);
    step(1, 5, 1, 0, 5, 4'hF, 4'h0, -1, -1, -1);
    step(0, 0, 0, 1, 5, 4'hF, 4'h0, 2, -1, -1);
    step(0, 0, 0, 1, 6, 4'hF, 4'h0, 0, 0, -1);
    // Invalid way wins; invalid-but-locked falls back to candidate path.
    step(0, 0, 0, 1, 9, 4'b1011, 4'h0, 2, 2, 2);
    step(0, 0, 0, 1, 9, 4'b1011, 4'b0100, -1, -1, -1);
    // Locked candidate scans upward; fully locked stalls.
    step(1, 7, 0, 0, 7, 4'hF, 4'h0, -1, -1, -1);
    step(0, 0, 0, 1, 7, 4'hF, 4'b0010, 2, -1, -1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 7, 4'hF, 4'hF, 0, 0, 0);
    #1;
    chk("stall_after_3", int'(sc0), 3);
    step(0, 0, 0, 0, 7, 4'hF, 4'h0, -1, -1, -1);
    // Same-cycle access and lookup on set 2.
    step(1, 2, 0, 1, 2, 4'hF, 4'h0, 0, -1, -1);
    step(0, 0, 0, 1, 2, 4'hF, 4'h0, 1, -1, -1);
    // Random traffic over a few sets so state is reused heavily.
    for (int n = 0; n < 1500; n++) begin
      logic [NW-1:0] vm;
      logic [NW-1:0] lm;
      int r;
      r  = $urandom_range(0, 99);
      vm = (r < 75) ? 4'hF : 4'($urandom);
      r  = $urandom_range(0, 99);
      lm = (r < 70) ? 4'h0 : (r < 90) ? 4'($urandom) : 4'hF;
      step(bit'($urandom_range(0, 1)), $urandom_range(0, 7), $urandom_range(0, NW - 1),
           bit'($urandom_range(0, 1)), $urandom_range(0, 7), vm, lm, -1, -1, -1);
    end
    // Mid-stream reset, then the LFSR sequence must restart from the seed.
    do_reset();
    step(0, 0, 0, 1, 3, 4'hF, 4'h0, 0, 0, 1);
    for (int n = 0; n < 20; n++)
      step(bit'($urandom_range(0, 1)), $urandom_range(0, 7), $urandom_range(0, NW - 1),
           1'b1, $urandom_range(0, 7), 4'hF, 4'h0, -1, -1, -1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/replacement_policy.md
REPLACEMENT_POLICY -- requirements
Module: replacement_policy

Interface
REQ-001 SHALL have parameter NUM_SETS, default 64, number of cache sets (power of two, >=2).
REQ-002 SHALL have parameter NUM_WAYS, default 4, associativity (power of two, 2..16).
REQ-003 SHALL have parameter POLICY, default 1, replacement mode: 0 round-robin, 1 tree-PLRU, 2 LFSR-random.
REQ-004 SHALL have parameter LFSR_SEED, default 16'hACE1, LFSR reset value (nonzero).
REQ-005 SHALL derive INDEX_BITS = clog2(NUM_SETS), WAY_BITS = clog2(NUM_WAYS).
REQ-006 clk  input  1  sole clock, all state on rising edge.
REQ-007 rst  input  1  asynchronous, active-high reset.
REQ-008 access_en  input  1  hit or fill touch; updates recency state of access_index.
REQ-009 access_index  input  INDEX_BITS  set touched.
REQ-010 access_way  input  WAY_BITS  way touched.
REQ-011 lookup_en  input  1  victim request qualifier (drives stall counter only).
REQ-012 lookup_index  input  INDEX_BITS  set for victim selection.
REQ-013 valid_mask  input  NUM_WAYS  line-valid bits of lookup_index set.
REQ-014 lock_mask  input  NUM_WAYS  ways excluded from replacement, all sets.
REQ-015 victim_way  output  WAY_BITS  selected victim, combinational from current state.
REQ-016 victim_valid  output  1  1 when any unlocked way exists.
REQ-017 stall_cnt  output  16  saturating count of cycles lookup_en=1 and victim_valid=0.

Function
REQ-018 Per-set state: mode 0 WAY_BITS pointer; mode 1 NUM_WAYS-1 tree bits; mode 2 no per-set state, one shared 16-bit LFSR.
REQ-019 Unused-mode storage SHALL not be instantiated (generate on POLICY).
REQ-020 Mode 0 candidate = pointer[lookup_index]; on access_en pointer[access_index] <= (access_way+1) mod NUM_WAYS.
REQ-021 Mode 1 tree: node bit 0 -> candidate in lower half, 1 -> upper half, root to leaf; on access_en every node on access_way path set to point to the half NOT containing access_way.
REQ-022 Mode 2 LFSR: Fibonacci, taps 16,14,13,11, shifts every cycle when not in reset; candidate = lfsr[WAY_BITS-1:0]; access_en has no effect.
REQ-023 Victim priority: (a) lowest-index way with valid_mask=0 and lock_mask=0; else (b) candidate if unlocked; else (c) first unlocked way scanning upward from candidate+1 with wrap.
REQ-024 All ways locked: victim_valid=0, victim_way=0.
REQ-025 Invalid-but-locked ways SHALL never be selected.
REQ-026 access_en and lookup to same index in one cycle: victim reflects pre-update state; update visible next cycle.
REQ-027 access_en updates exactly one set; other sets unchanged.
REQ-028 stall_cnt increments by 1 per qualifying cycle, holds at 16'hFFFF.
REQ-029 No handshake latency: victim_way/victim_valid valid same cycle as lookup inputs; state update latency 1 cycle.

Reset
REQ-030 On rst=1, immediately (asynchronously): all pointers 0, all tree bits 0, lfsr=LFSR_SEED, stall_cnt=0.
REQ-031 Reset mid-operation SHALL discard pending updates; access_en during rst ignored.
REQ-032 After reset release, victim_way=0 in modes 0/1 with all valid and unlocked; mode 2 first candidate = LFSR_SEED[WAY_BITS-1:0] (=1 for default).

Verification
REQ-033 Mode 1, 4 ways, set 3, all valid, no locks: access way0, access way1 -> victim 2; then access way2 -> victim 0.
REQ-034 Mode 0, set 5: access way3 -> victim 0 (wrap); access way1 -> victim 2; set 6 still victim 0.
REQ-035 Any mode: valid_mask=4'b1011, lock_mask=0 -> victim 2; valid_mask=4'b1011, lock_mask=4'b0100 -> policy candidate path.
REQ-036 Mode 0, pointer=1, all valid, lock_mask=4'b0010 -> victim 2; lock_mask=4'b1111, lookup_en=1 for 3 cycles -> victim_valid=0, stall_cnt=3.
REQ-037 Same-cycle access_en and lookup on set 2 (mode 0, pointer 0, access way0) -> victim 0 that cycle, 1 next cycle.
REQ-038 Assert rst mid-stream after tree updates -> outputs immediately reset values (victim 0, stall_cnt 0); mode 2 sequence restarts from LFSR_SEED.
